// File: rtl/phasegen.sv
// Four-phase instruction sequencer (IF/DE/EX/WB) with run, stop and single-step control.
// Optional breakpoint-on-PC support is compiled in when PHASEGEN_BREAKPOINT_EN is defined.
module phasegen (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_run,
    input  logic        i_stop,
    input  logic        i_step_phase,
    input  logic        i_step_inst,
    input  logic        i_mem_wait,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_bp_addr,
    input  logic        i_bp_en,
    output logic [3:0]  o_cstate,
    output logic        o_running,
    output logic        o_bp_hit
);

    localparam logic [3:0] PhIf = 4'b0001;
    localparam logic [3:0] PhWb = 4'b1000;

    typedef enum logic [1:0] {ModeStop, ModeRun, ModeStepI} mode_e;

    mode_e      r_mode, w_mode_nxt;
    logic [3:0] r_phase, w_phase_nxt;
    logic       r_stop_req, w_stop_req_nxt;
    logic       w_onehot, w_stall, w_adv, w_accept, w_resume, w_bp_stop;

    assign w_onehot = (r_phase == 4'b0001) || (r_phase == 4'b0010) ||
                      (r_phase == 4'b0100) || (r_phase == 4'b1000);
    assign w_stall  = (r_phase == PhWb) && i_mem_wait;

    always_comb begin
        w_mode_nxt     = r_mode;
        w_phase_nxt    = r_phase;
        w_stop_req_nxt = r_stop_req;
        w_adv          = 1'b0;
        w_accept       = 1'b0;
        w_resume       = 1'b0;
        case (r_mode)
            ModeStop: begin
                if (i_step_inst) begin
                    w_mode_nxt = ModeStepI;
                    w_accept   = 1'b1;
                    w_resume   = 1'b1;
                end else if (i_step_phase) begin
                    // A step requested during a WB stall is dropped, not deferred.
                    w_adv    = !w_stall;
                    w_accept = !w_stall;
                end else if (i_run) begin
                    w_mode_nxt = ModeRun;
                    w_accept   = 1'b1;
                    w_resume   = 1'b1;
                end
            end
            ModeRun: begin
                if (w_bp_stop) begin
                    w_mode_nxt     = ModeStop;
                    w_stop_req_nxt = 1'b0;
                end else begin
                    w_adv = !w_stall;
                    if (w_adv && (r_phase == PhWb) && r_stop_req) begin
                        w_mode_nxt     = ModeStop;
                        w_stop_req_nxt = 1'b0;
                    end else if (i_stop) begin
                        w_stop_req_nxt = 1'b1;
                    end
                end
            end
            ModeStepI: begin
                w_adv = !w_stall;
                if (w_adv && (r_phase == PhWb)) begin
                    w_mode_nxt = ModeStop;
                end
            end
            default: begin
                w_mode_nxt     = ModeStop;
                w_stop_req_nxt = 1'b0;
            end
        endcase
        if (!w_onehot) begin
            w_phase_nxt = PhIf;
        end else if (w_adv) begin
            w_phase_nxt = {r_phase[2:0], r_phase[3]};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mode     <= ModeStop;
            r_phase    <= PhIf;
            r_stop_req <= 1'b0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_phase    <= w_phase_nxt;
            r_stop_req <= w_stop_req_nxt;
        end
    end

`ifdef PHASEGEN_BREAKPOINT_EN
    logic r_skip, w_skip_nxt;
    logic r_bp_hit, w_bp_hit_nxt;

    // The skip flag lets a resumed run leave the breakpointed IF once.
    assign w_bp_stop = (r_mode == ModeRun) && (r_phase == PhIf) && i_bp_en &&
                       (i_pc == i_bp_addr) && !r_skip;

    always_comb begin
        w_skip_nxt   = r_skip;
        w_bp_hit_nxt = r_bp_hit;
        if (w_resume) begin
            w_skip_nxt = 1'b1;
        end else if (w_adv && (r_phase == PhIf)) begin
            w_skip_nxt = 1'b0;
        end
        if (w_bp_stop) begin
            w_bp_hit_nxt = 1'b1;
        end else if (w_accept) begin
            w_bp_hit_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_skip   <= 1'b0;
            r_bp_hit <= 1'b0;
        end else begin
            r_skip   <= w_skip_nxt;
            r_bp_hit <= w_bp_hit_nxt;
        end
    end

    assign o_bp_hit = r_bp_hit;
`else
    logic w_unused;
    assign w_unused  = ^{i_pc, i_bp_addr, i_bp_en, w_accept, w_resume};
    assign w_bp_stop = 1'b0;
    assign o_bp_hit  = 1'b0;
`endif

    assign o_cstate  = r_phase;
    assign o_running = (r_mode != ModeStop);

endmodule

// File: tb/tb_phasegen.sv
// Self-checking bench for phasegen: directed scenarios plus randomized commands,
// all checked against an integer-level model of the phase/mode rules.
module tb_phasegen;

    logic        clock = 1'b0;
    logic        reset, run, stop, step_phase, step_inst, mem_wait, bp_en;
    logic [31:0] pc, bp_addr;
    logic [3:0]  cstate;
    logic        running, bp_hit;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: phase as 0..3 (IF..WB), mode 0=STOP 1=RUN 2=STEP_I.
    int m_phase, m_mode;
    bit m_req, m_skip, m_bp;

    phasegen u_dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_run       (run),
        .i_stop      (stop),
        .i_step_phase(step_phase),
        .i_step_inst (step_inst),
        .i_mem_wait  (mem_wait),
        .i_pc        (pc),
        .i_bp_addr   (bp_addr),
        .i_bp_en     (bp_en),
        .o_cstate    (cstate),
        .o_running   (running),
        .o_bp_hit    (bp_hit)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit adv, stall, bp_on;
        adv   = 0;
        stall = (m_phase == 3) && mem_wait;
`ifdef PHASEGEN_BREAKPOINT_EN
        bp_on = 1;
`else
        bp_on = 0;
`endif
        if (reset) begin
            m_phase = 0; m_mode = 0; m_req = 0; m_skip = 0; m_bp = 0;
            return;
        end
        if (m_mode == 0) begin
            if (step_inst) begin
                m_mode = 2; m_bp = 0; m_skip = 1;
            end else if (step_phase) begin
                if (!stall) begin adv = 1; m_bp = 0; end
            end else if (run) begin
                m_mode = 1; m_bp = 0; m_skip = 1;
            end
        end else if (m_mode == 1) begin
            if (bp_on && m_phase == 0 && bp_en && pc == bp_addr && !m_skip) begin
                m_mode = 0; m_bp = 1; m_req = 0;
            end else begin
                adv = !stall;
                if (adv && m_phase == 3 && m_req) begin
                    m_mode = 0; m_req = 0;
                end else if (stop) begin
                    m_req = 1;
                end
            end
        end else begin
            adv = !stall;
            if (adv && m_phase == 3) m_mode = 0;
        end
        if (adv) begin
            if (m_phase == 0) m_skip = 0;
            m_phase = (m_phase + 1) % 4;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check_eq("cstate", {28'd0, cstate}, 32'd1 << m_phase);
        check_eq("running", {31'd0, running}, {31'd0, m_mode != 0});
        check_eq("bp_hit", {31'd0, bp_hit}, {31'd0, m_bp});
    endtask

    task automatic clr_in();
        reset = 0; run = 0; stop = 0; step_phase = 0; step_inst = 0; mem_wait = 0;
    endtask

    task automatic do_reset();
        clr_in(); reset = 1; tick(); reset = 0;
    endtask

    initial begin
        clr_in();
        bp_en = 0; pc = 32'h0; bp_addr = 32'h10;
        m_phase = 0; m_mode = 0; m_req = 0; m_skip = 0; m_bp = 0;
        do_reset();
        check_eq("reset_cstate", {28'd0, cstate}, 32'h1);
        check_eq("reset_running", {31'd0, running}, 32'h0);

        // Run from reset: IF held one edge, then advances every edge.
        run = 1; tick(); run = 0;
        check_eq("run_k_cstate", {28'd0, cstate}, 32'h1);
        check_eq("run_k_running", {31'd0, running}, 32'h1);
        tick(); check_eq("run_de", {28'd0, cstate}, 32'h2);
        tick(); check_eq("run_ex", {28'd0, cstate}, 32'h4);
        tick(); check_eq("run_wb", {28'd0, cstate}, 32'h8);
        // WB stall for three edges.
        mem_wait = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_eq("stall_wb", {28'd0, cstate}, 32'h8);
        end
        mem_wait = 0; tick(); check_eq("stall_release", {28'd0, cstate}, 32'h1);

        // Stop requested at DE finishes the instruction and parks at IF.
        tick(); check_eq("stop_de", {28'd0, cstate}, 32'h2);
        stop = 1; tick(); stop = 0;
        check_eq("stop_ex", {28'd0, cstate}, 32'h4);
        tick(); check_eq("stop_wb_run", {31'd0, running}, 32'h1);
        tick(); check_eq("stop_if", {28'd0, cstate}, 32'h1);
        check_eq("stop_running", {31'd0, running}, 32'h0);
        tick(); check_eq("stop_hold", {28'd0, cstate}, 32'h1);

        // Single phase steps spaced two cycles apart.
        for (int i = 0; i < 4; i++) begin
            step_phase = 1; tick(); step_phase = 0;
            check_eq("step_phase", {28'd0, cstate}, 32'd1 << ((i + 1) % 4));
            check_eq("step_running", {31'd0, running}, 32'h0);
            tick();
        end

        // STEP_I from EX, reset during a WB stall abandons it.
        step_phase = 1; tick(); tick(); step_phase = 0;
        check_eq("si_at_ex", {28'd0, cstate}, 32'h4);
        step_inst = 1; tick(); step_inst = 0;
        check_eq("si_running", {31'd0, running}, 32'h1);
        tick(); check_eq("si_wb", {28'd0, cstate}, 32'h8);
        mem_wait = 1; tick();
        reset = 1; tick(); reset = 0;
        check_eq("si_rst_cstate", {28'd0, cstate}, 32'h1);
        check_eq("si_rst_running", {31'd0, running}, 32'h0);
        mem_wait = 0; tick(); check_eq("si_rst_hold", {28'd0, cstate}, 32'h1);

`ifdef PHASEGEN_BREAKPOINT_EN
        // Breakpoint at 0x10: first pass skipped, second IF visit hits.
        do_reset();
        bp_en = 1; pc = 32'h0;
        run = 1; tick(); run = 0;
        tick(); tick(); tick();
        pc = 32'h10; tick();
        check_eq("bp_pre_if", {28'd0, cstate}, 32'h1);
        tick();
        check_eq("bp_cstate", {28'd0, cstate}, 32'h1);
        check_eq("bp_hit", {31'd0, bp_hit}, 32'h1);
        check_eq("bp_running", {31'd0, running}, 32'h0);
        run = 1; tick(); run = 0;
        check_eq("bp_clear", {31'd0, bp_hit}, 32'h0);
        tick(); check_eq("bp_resume", {28'd0, cstate}, 32'h2);
        bp_en = 0;
`endif

        // Randomized commands against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            run        = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 11) == 0);
            step_phase = ($urandom_range(0, 7) == 0);
            step_inst  = ($urandom_range(0, 19) == 0);
            mem_wait   = ($urandom_range(0, 2) == 0);
            bp_en      = $urandom_range(0, 1) == 1;
            pc         = ($urandom_range(0, 3) == 0) ? 32'h10 : 32'($urandom_range(0, 31));
            tick();
        end
        clr_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/phasegen.md
PHASEGEN -- requirements
Module: phasegen

Interface
REQ-001 SHALL have ports, in this order:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  pulse: start continuous execution
- stop  in  1  pulse: request stop at the next instruction boundary
- step_phase  in  1  pulse: advance exactly one phase
- step_inst  in  1  pulse: execute to the end of the current instruction
- mem_wait  in  1  memory not ready; stalls WB
- pc  in  32  current PC register value
- bp_addr  in  32  breakpoint address
- bp_en  in  1  breakpoint enable
- cstate  out  4  one-hot phase: IF=0001, DE=0010, EX=0100, WB=1000
- running  out  1  high when the mode is RUN or STEP_I
- bp_hit  out  1  sticky breakpoint-stop flag
REQ-002 SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clock.

Function
REQ-003 SHALL keep a control mode register with states STOP, RUN and STEP_I, plus a one-hot phase register that drives cstate directly from a flop.
REQ-004 An advance SHALL move the phase IF->DE->EX->WB->IF, one step per advancing edge.
REQ-005 The phase SHALL NOT advance at any edge where cstate==WB and mem_wait=1, in any mode. step_phase sampled during such a stall SHALL be discarded.
REQ-006 STOP: the phase SHALL hold unless a command is sampled. Priority when commands coincide: step_inst > step_phase > run. stop SHALL be ignored in STOP.
REQ-007 STOP + step_phase sampled at edge k: exactly one advance at edge k; the mode stays STOP.
REQ-008 STOP + run sampled at edge k: mode=RUN and running=1 after edge k, with no advance at edge k. Advances then occur every edge from k+1 onward.
REQ-009 STOP + step_inst sampled at edge k: mode=STEP_I and running=1 after edge k. Advances occur from k+1 onward until the WB->IF advance; at that edge mode=STOP and running=0.
REQ-010 RUN: stop sampled sets an internal stop_req. At the next WB->IF advance, mode=STOP, running=0 and stop_req clears, so the block always stops with cstate=IF.
REQ-011 run, step_phase and step_inst SHALL be ignored while the mode is RUN or STEP_I. stop sampled in STEP_I SHALL be ignored.
REQ-012 cstate SHALL be exactly one-hot at every edge; any non-one-hot value SHALL be forced to IF on the next edge.
REQ-013 Each accepted run, step_phase or step_inst SHALL clear bp_hit at the edge where it is accepted.

Reset
REQ-014 reset=1 at an edge SHALL set cstate=0001, mode=STOP, running=0, bp_hit=0, stop_req=0 and the breakpoint skip flag=0. Reset SHALL override all other inputs.
REQ-015 Reset asserted mid-instruction, including during a WB stall, SHALL abandon the instruction, with no further advance until a new command arrives.

Configuration
REQ-016 Macro PHASEGEN_BREAKPOINT_EN SHALL control the breakpoint feature.
- Defined: in RUN, if cstate==IF, bp_en=1, pc==bp_addr and the skip flag=0, the IF->DE advance SHALL be suppressed at that edge; mode=STOP, running=0, bp_hit=1.
- Defined: an accepted run or step_inst SHALL set the skip flag. The skip flag SHALL clear at the first IF->DE advance, so resuming from a breakpoint does not re-hit it immediately.
- Not defined: bp_addr and bp_en SHALL be present but ignored, bp_hit SHALL be tied to 0, and no breakpoint logic SHALL be synthesized.

Verification
REQ-017 Reset, then run pulse at cycle 0 -> cstate sequence 0001,0001,0010,0100,1000,0001,... with running=1 from cycle 1.
REQ-018 STOP at IF, four step_phase pulses spaced two cycles apart -> cstate 0010,0100,1000,0001 with running=0 throughout.
REQ-019 RUN with mem_wait=1 held for 3 cycles while cstate=1000 -> cstate stays 1000 for 3 extra cycles, then becomes 0001.
REQ-020 RUN, stop pulsed while cstate=0010 -> block continues through 0100 and 1000, stops at 0001 with running=0.
REQ-021 PHASEGEN_BREAKPOINT_EN defined, bp_en=1, bp_addr=0x00000010, pc reaches 0x10 in IF -> cstate holds 0001, bp_hit=1, running=0. A following run pulse -> bp_hit=0 and the block advances past IF.
REQ-022 STEP_I started at cstate=0100 with reset asserted during WB -> cstate=0001, running=0, mode STOP on the next edge.
